// File: rtl/sum_argmax_reader_pkg.sv
// Shared widths for the layer-2 argmax stage and the compare-result
// encoding used by the scan datapath.
`ifndef LAYER_2_OUT_BIT_WIDTH
`define LAYER_2_OUT_BIT_WIDTH 16
`endif
`ifndef NUM_CLASSES
`define NUM_CLASSES 10
`endif
`ifndef CLASS_IDX_BIT_WIDTH
`define CLASS_IDX_BIT_WIDTH 4
`endif

package sum_argmax_reader_pkg;

   localparam int NUM_CLASSES = `NUM_CLASSES;
   localparam int CLASS_IDX_W = `CLASS_IDX_BIT_WIDTH;

   typedef enum logic [1:0] {
      CMP_LESS    = 2'd0,
      CMP_EQUAL   = 2'd1,
      CMP_GREATER = 2'd2
   } cmp_e;

   function automatic cmp_e cmp_decode(input logic gt, input logic eq);
      cmp_e r;
      if (gt)      r = CMP_GREATER;
      else if (eq) r = CMP_EQUAL;
      else         r = CMP_LESS;
      return r;
   endfunction

endpackage

// File: rtl/sum_argmax_reader_signed_max_step.sv
// One argmax step: full-width signed compare of a candidate against the
// running best, reported as greater / equal flags.
module signed_max_step #(
   parameter int W = 16
) (
   input  logic [W-1:0] cand_i,
   input  logic [W-1:0] best_i,
   output logic         gt_o,
   output logic         eq_o
);

   assign gt_o = $signed(cand_i) > $signed(best_i);
   assign eq_o = cand_i == best_i;

endmodule

// File: rtl/sum_argmax_reader.sv
// Snapshots the ten layer-2 sums on start, scans them one lane per cycle and
// publishes the signed argmax, its value and a tie flag with a done pulse.
module sum_argmax_reader
   import sum_argmax_reader_pkg::*;
#(
   parameter int OUT_W     = `LAYER_2_OUT_BIT_WIDTH,
   parameter int N_CLASSES = `NUM_CLASSES
) (
   input  logic                       clk,
   input  logic                       clr,
   input  logic [N_CLASSES*OUT_W-1:0] sumIn,
   input  logic                       start,
   output logic                       busy,
   output logic                       done,
   output logic [CLASS_IDX_W-1:0]     classOut,
   output logic [OUT_W-1:0]           maxOut,
   output logic                       tieOut,
   output logic [1:0]                 stateDbg
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SCAN = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam logic [CLASS_IDX_W-1:0] LAST_IDX = CLASS_IDX_W'(N_CLASSES - 1);

   logic [1:0]             state_q, state_d;
   logic [OUT_W-1:0]       snap_q [N_CLASSES];
   logic [CLASS_IDX_W-1:0] idx_q, idx_d;
   logic [CLASS_IDX_W-1:0] best_idx_q, best_idx_d;
   logic [OUT_W-1:0]       best_q, best_d;
   logic                   tie_q, tie_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic [CLASS_IDX_W-1:0] class_q, class_d;
   logic [OUT_W-1:0]       max_q, max_d;
   logic                   tie_out_q, tie_out_d;

   logic [OUT_W-1:0] cand;
   logic             cand_gt, cand_eq;
   cmp_e             cmp;
   logic             take;

   // idx_q never leaves 0..N_CLASSES-1, so the lane select stays in range.
   assign cand = snap_q[idx_q];
   assign take = (state_q == S_IDLE) && start;
   assign cmp  = cmp_decode(cand_gt, cand_eq);

   signed_max_step #(.W(OUT_W)) u_step (
      .cand_i (cand),
      .best_i (best_q),
      .gt_o   (cand_gt),
      .eq_o   (cand_eq)
   );

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      best_idx_d = best_idx_q;
      best_d     = best_q;
      tie_d      = tie_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      class_d    = class_q;
      max_d      = max_q;
      tie_out_d  = tie_out_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d    = S_SCAN;
               best_d     = sumIn[OUT_W-1:0];
               best_idx_d = '0;
               tie_d      = 1'b0;
               idx_d      = CLASS_IDX_W'(1);
               busy_d     = 1'b1;
            end
         end
         S_SCAN: begin
            // Only a strict win replaces the best, so ties keep the lowest index.
            case (cmp)
               CMP_GREATER: begin
                  best_d     = cand;
                  best_idx_d = idx_q;
                  tie_d      = 1'b0;
               end
               CMP_EQUAL: tie_d = 1'b1;
               default: ;
            endcase
            if (idx_q == LAST_IDX) state_d = S_DONE;
            else                   idx_d   = idx_q + CLASS_IDX_W'(1);
         end
         S_DONE: begin
            class_d   = best_idx_q;
            max_d     = best_q;
            tie_out_d = tie_q;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            state_d   = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         best_idx_q <= '0;
         best_q     <= '0;
         tie_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         class_q    <= '0;
         max_q      <= '0;
         tie_out_q  <= 1'b0;
         for (int m = 0; m < N_CLASSES; m++) snap_q[m] <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         best_idx_q <= best_idx_d;
         best_q     <= best_d;
         tie_q      <= tie_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         class_q    <= class_d;
         max_q      <= max_d;
         tie_out_q  <= tie_out_d;
         if (take) begin
            for (int m = 0; m < N_CLASSES; m++) snap_q[m] <= sumIn[m*OUT_W +: OUT_W];
         end
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign classOut = class_q;
   assign maxOut   = max_q;
   assign tieOut   = tie_out_q;
   assign stateDbg = state_q;

endmodule
